// File: rtl/dac_serial_tx.sv
// dac_serial_tx: multi-channel serial DAC transmitter with a 1-entry frame buffer,
// free-running bit-clock divider and selectable I2S / left-justified framing.
module dac_serial_tx #(
   parameter int DATA_W   = 24,
   parameter int CHANNELS = 2,
   parameter int DIV      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS*DATA_W-1:0] sample_data,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic                       i2s_mode,
   output logic                       sclk,
   output logic                       sdata,
   output logic                       lrck,
   output logic                       frame_start,
   output logic                       underrun
);

   localparam int FRAME_W = CHANNELS * DATA_W;
   localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W   = $clog2(DATA_W);
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic [FRAME_W-1:0]   buf_data, ordered;
   logic                 buf_full_q, buf_full_d;
   logic                 mode_q, mode_d;
   logic                 lag_q, lag_d;
   logic                 sclk_d, sdata_d, lrck_d, frame_start_d, underrun_d;
   logic                 boundary, last_bit, load, write;

   assign boundary     = (cnt_q == CNT_W'(DIV - 1));
   assign last_bit     = (ch_q == CH_W'(CHANNELS - 1)) && (bit_q == BIT_W'(DATA_W - 1));
   assign load         = boundary && buf_full_q && ((state_q == IDLE) || last_bit);
   assign write        = sample_valid && !buf_full_q;
   assign sample_ready = ~buf_full_q;

   // Shift order is channel 0 first, so channel 0 lands in the top bits.
   always_comb begin
      ordered = '0;
      for (int k = 0; k < CHANNELS; k++)
         ordered[(CHANNELS-1-k)*DATA_W +: DATA_W] = buf_data[k*DATA_W +: DATA_W];
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      cnt_d         = boundary ? '0 : cnt_q + 1'b1;
      bit_d         = bit_q;
      ch_d          = ch_q;
      shreg_d       = shreg_q;
      mode_d        = mode_q;
      lag_d         = lag_q;
      sdata_d       = sdata;
      lrck_d        = lrck;
      frame_start_d = 1'b0;

      buf_full_d = buf_full_q;
      if (load)
         buf_full_d = 1'b0;
      else if (write)
         buf_full_d = 1'b1;

      if (boundary) begin
         // lag holds the bit just finished; I2S framing sends it one bit late.
         lag_d   = shreg_q[FRAME_W-1];
         shreg_d = shreg_q << 1;
         if (load) begin
            state_d       = SHIFT;
            shreg_d       = ordered;
            bit_d         = '0;
            ch_d          = '0;
            mode_d        = i2s_mode;
            frame_start_d = 1'b1;
         end else if (state_q == SHIFT) begin
            if (last_bit) begin
               state_d = IDLE;
               bit_d   = '0;
               ch_d    = '0;
            end else if (bit_q == BIT_W'(DATA_W - 1)) begin
               bit_d = '0;
               ch_d  = ch_q + 1'b1;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         sdata_d = mode_d ? lag_d : shreg_d[FRAME_W-1];
         lrck_d  = (state_d == SHIFT) ? ch_d[0] : 1'b0;
      end

      sclk_d     = (cnt_d >= CNT_W'(DIV / 2));
      // Raised during the final clk of a frame that has nothing queued behind it.
      underrun_d = (cnt_d == CNT_W'(DIV - 1)) && (state_q == SHIFT) && last_bit && !buf_full_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         ch_q        <= '0;
         shreg_q     <= '0;
         buf_full_q  <= 1'b0;
         mode_q      <= 1'b0;
         lag_q       <= 1'b0;
         sclk        <= 1'b0;
         sdata       <= 1'b0;
         lrck        <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         ch_q        <= ch_d;
         shreg_q     <= shreg_d;
         buf_full_q  <= buf_full_d;
         mode_q      <= mode_d;
         lag_q       <= lag_d;
         sclk        <= sclk_d;
         sdata       <= sdata_d;
         lrck        <= lrck_d;
         frame_start <= frame_start_d;
         underrun    <= underrun_d;
      end
   end

   // NOTE: buffer contents need no reset; buf_full_q alone says whether they mean anything.
   always_ff @(posedge clk) begin
      if (write)
         buf_data <= sample_data;
   end

endmodule
